// File: rtl/idx_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : idx_buf_pkg
// Description : Shared constants, FSM state encodings and helpers for the
//               index buffer read scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package idx_buf_pkg;

    // The index BRAM bank is fixed at 16 rows, so the row tag is 4 bits.
    localparam int c_RAM_ROW   = 16;
    localparam int c_ROW_TAG_W = 4;

    // Scheduler states.
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT_WR = 2'd1;
    localparam logic [1:0] c_ST_READ    = 2'd2;
    localparam logic [1:0] c_ST_DRAIN   = 2'd3;

    // A tile is striped evenly over the 16 rows, so each row holds
    // Addr_end / 16 words.
    function automatic logic [31:0] f_row_len(input logic [31:0] addr_end);
        return addr_end >> 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idx_row_mux.sv
`default_nettype none
// ============================================================================
// Module      : idx_row_mux
// Description : 16:1 word multiplexer that picks one BRAM row's read data.
// Ports       : i_data_row  - all rows' read data, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//               i_sel       - row select
//               o_data      - selected row's data
// Revision    : 1.0  initial release
// ============================================================================
module idx_row_mux
    import idx_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH*c_RAM_ROW-1:0] i_data_row,
    input  logic [c_ROW_TAG_W-1:0]          i_sel,
    output logic [DATA_WIDTH-1:0]           o_data
);

    logic [DATA_WIDTH-1:0] w_rows [c_RAM_ROW];

    for (genvar r = 0; r < c_RAM_ROW; r++) begin : g_rows
        assign w_rows[r] = i_data_row[r*DATA_WIDTH +: DATA_WIDTH];
    end

    assign o_data = w_rows[i_sel];

endmodule
`default_nettype wire

// File: rtl/index_buff_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : index_buff_rd_sched
// Description : Read-side scheduler for the 16-row index BRAM bank. After a
//               tile is fully written it reads every row (row 0..15, address
//               0..len-1 per row), optionally repeating the whole tile
//               pass_num+1 times, and streams one index word per beat over a
//               valid/ready handshake.
// Ports       : clk, rst (sync, active-low)
//               start, wr_finished, Addr_end, pass_num  - tile control
//               rd_data_row / rd_addr_row / rd_en_row   - BRAM bank (1-cycle latency)
//               idx_data/idx_valid/idx_ready/idx_row/idx_last - consumer stream
//               pass_done, done, busy                   - status
// Options     : define IDX_RD_PERF_EN to add stall_cnt[15:0], a saturating
//               count of READ/DRAIN cycles with idx_valid && !idx_ready.
// Revision    : 1.0  initial release
// ============================================================================
module index_buff_rd_sched
    import idx_buf_pkg::*;
#(
    parameter int RAM_ROW         = c_RAM_ROW,  // must stay 16
    parameter int READ_ADDR_WIDTH = 11,
    parameter int DATA_WIDTH      = 64,
    parameter int PASS_WIDTH      = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               wr_finished,
    input  logic [READ_ADDR_WIDTH+4:0]         Addr_end,
    input  logic [PASS_WIDTH-1:0]              pass_num,
    input  logic [DATA_WIDTH*RAM_ROW-1:0]      rd_data_row,
    output logic [READ_ADDR_WIDTH*RAM_ROW-1:0] rd_addr_row,
    output logic [RAM_ROW-1:0]                 rd_en_row,
    output logic [DATA_WIDTH-1:0]              idx_data,
    output logic                               idx_valid,
    input  logic                               idx_ready,
    output logic [c_ROW_TAG_W-1:0]             idx_row,
    output logic                               idx_last,
    output logic                               pass_done,
    output logic                               done,
    output logic                               busy
`ifdef IDX_RD_PERF_EN
    ,
    output logic [15:0]                        stall_cnt
`endif
);

    // Column counter carries one extra bit so it can be compared against the
    // full row length without overflow.
    localparam int c_LEN_W = READ_ADDR_WIDTH + 1;
    localparam logic [c_ROW_TAG_W-1:0] c_LAST_ROW = c_ROW_TAG_W'(c_RAM_ROW - 1);

    logic [1:0]             r_state, w_state_nxt;
    logic [c_LEN_W-1:0]     r_len, w_len_nxt;
    logic [PASS_WIDTH-1:0]  r_pass_num, w_pass_num_nxt;
    logic [PASS_WIDTH-1:0]  r_pass_cnt, w_pass_cnt_nxt;
    logic [c_ROW_TAG_W-1:0] r_row, w_row_nxt;
    logic [c_LEN_W-1:0]     r_col, w_col_nxt;
    logic                   r_idx_valid, w_idx_valid_nxt;
    logic [c_ROW_TAG_W-1:0] r_idx_row, w_idx_row_nxt;
    logic                   r_idx_last, w_idx_last_nxt;
    logic                   r_pass_done, w_pass_done_nxt;
    logic                   r_done, w_done_nxt;

    logic [c_LEN_W-1:0]     w_len_new;
    logic                   w_len_zero;
    logic                   w_last_col;
    logic                   w_last_issue;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_final_accept;
    logic [DATA_WIDTH-1:0]  w_mux_data;

    assign w_len_new      = c_LEN_W'(f_row_len(32'(Addr_end)));
    assign w_len_zero     = (r_len == '0);
    assign w_last_col     = (r_col == r_len - c_LEN_W'(1));
    assign w_last_issue   = w_last_col && (r_row == c_LAST_ROW);
    assign w_accept       = r_idx_valid && idx_ready;
    assign w_final_accept = w_accept && r_idx_last;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = wr_finished ? c_ST_READ : c_ST_WAIT_WR;
                end
            end
            c_ST_WAIT_WR: begin
                if (wr_finished) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                if (w_len_zero) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_issue && w_last_issue) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_final_accept) begin
                    w_state_nxt = (r_pass_cnt < r_pass_num) ? c_ST_READ : c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (BRAM read port)
    // A read is issued whenever the output slot is free or being drained
    // this cycle. Reads are suppressed while reset is asserted so the bank
    // sees no enable during the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_issue     = rst && (r_state == c_ST_READ) && !w_len_zero &&
                      (!r_idx_valid || idx_ready);
        rd_en_row   = '0;
        rd_addr_row = '0;
        if (w_issue) begin
            rd_en_row[r_row] = 1'b1;
            rd_addr_row[r_row*READ_ADDR_WIDTH +: READ_ADDR_WIDTH] =
                r_col[READ_ADDR_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state: counters, tile parameters and output tags
    // ------------------------------------------------------------------
    always_comb begin
        w_len_nxt       = r_len;
        w_pass_num_nxt  = r_pass_num;
        w_pass_cnt_nxt  = r_pass_cnt;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_idx_valid_nxt = r_idx_valid;
        w_idx_row_nxt   = r_idx_row;
        w_idx_last_nxt  = r_idx_last;
        w_pass_done_nxt = 1'b0;
        w_done_nxt      = 1'b0;

        // Tags follow the read by one cycle, matching BRAM latency. A slot
        // that is accepted without a replacement read empties.
        if (w_issue) begin
            w_idx_valid_nxt = 1'b1;
            w_idx_row_nxt   = r_row;
            w_idx_last_nxt  = w_last_issue;
            if (w_last_col) begin
                w_col_nxt = '0;
                // Row 15 is left in place; the next pass resets it from DRAIN.
                if (r_row != c_LAST_ROW) begin
                    w_row_nxt = r_row + c_ROW_TAG_W'(1);
                end
            end else begin
                w_col_nxt = r_col + c_LEN_W'(1);
            end
        end else if (w_accept) begin
            w_idx_valid_nxt = 1'b0;
            w_idx_last_nxt  = 1'b0;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_len_nxt      = w_len_new;
                    w_pass_num_nxt = pass_num;
                    w_pass_cnt_nxt = '0;
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                end
            end
            c_ST_READ: begin
                // An empty tile finishes immediately without touching the bank.
                if (w_len_zero) begin
                    w_pass_done_nxt = 1'b1;
                    w_done_nxt      = 1'b1;
                end
            end
            c_ST_DRAIN: begin
                if (w_final_accept) begin
                    w_pass_done_nxt = 1'b1;
                    if (r_pass_cnt < r_pass_num) begin
                        w_pass_cnt_nxt = r_pass_cnt + PASS_WIDTH'(1);
                        w_row_nxt      = '0;
                        w_col_nxt      = '0;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len       <= '0;
            r_pass_num  <= '0;
            r_pass_cnt  <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_idx_valid <= 1'b0;
            r_idx_row   <= '0;
            r_idx_last  <= 1'b0;
            r_pass_done <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_len       <= w_len_nxt;
            r_pass_num  <= w_pass_num_nxt;
            r_pass_cnt  <= w_pass_cnt_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_idx_valid <= w_idx_valid_nxt;
            r_idx_row   <= w_idx_row_nxt;
            r_idx_last  <= w_idx_last_nxt;
            r_pass_done <= w_pass_done_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output word: the BRAM holds its output while en is low, so selecting
    // by the registered row tag keeps idx_data stable through stalls. The
    // word is forced to zero whenever no beat is presented.
    // ------------------------------------------------------------------
    idx_row_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_idx_row_mux (
        .i_data_row (rd_data_row),
        .i_sel      (r_idx_row),
        .o_data     (w_mux_data)
    );

    assign idx_data  = r_idx_valid ? w_mux_data : '0;
    assign idx_valid = r_idx_valid;
    assign idx_row   = r_idx_row;
    assign idx_last  = r_idx_last;
    assign pass_done = r_pass_done;
    assign done      = r_done;
    assign busy      = (r_state != c_ST_IDLE);

`ifdef IDX_RD_PERF_EN
    logic [15:0] r_stall_cnt, w_stall_cnt_nxt;

    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if ((r_state == c_ST_IDLE) && start) begin
            w_stall_cnt_nxt = '0;
        end else if (((r_state == c_ST_READ) || (r_state == c_ST_DRAIN)) &&
                     r_idx_valid && !idx_ready && (r_stall_cnt != 16'hFFFF)) begin
            w_stall_cnt_nxt = r_stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_index_buff_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_index_buff_rd_sched
// Description : Scoreboard bench for index_buff_rd_sched with a behavioural
//               16-row BRAM bank (1-cycle latency, output held while en low).
// Revision    : 1.0  initial release
// ============================================================================
module tb_index_buff_rd_sched;

    localparam int RAW = 11;
    localparam int DW  = 64;
    localparam int PW  = 4;
    localparam int NR  = 16;

    typedef struct packed {
        logic [3:0]    row;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              wr_finished = 1'b0;
    logic [RAW+4:0]    Addr_end = '0;
    logic [PW-1:0]     pass_num = '0;
    logic [DW*NR-1:0]  rd_data_row;
    logic [RAW*NR-1:0] rd_addr_row;
    logic [NR-1:0]     rd_en_row;
    logic [DW-1:0]     idx_data;
    logic              idx_valid;
    logic              idx_ready = 1'b1;
    logic [3:0]        idx_row;
    logic              idx_last;
    logic              pass_done;
    logic              done;
    logic              busy;
`ifdef IDX_RD_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    index_buff_rd_sched #(
        .RAM_ROW         (NR),
        .READ_ADDR_WIDTH (RAW),
        .DATA_WIDTH      (DW),
        .PASS_WIDTH      (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wr_finished (wr_finished),
        .Addr_end    (Addr_end),
        .pass_num    (pass_num),
        .rd_data_row (rd_data_row),
        .rd_addr_row (rd_addr_row),
        .rd_en_row   (rd_en_row),
        .idx_data    (idx_data),
        .idx_valid   (idx_valid),
        .idx_ready   (idx_ready),
        .idx_row     (idx_row),
        .idx_last    (idx_last),
        .pass_done   (pass_done),
        .done        (done),
        .busy        (busy)
`ifdef IDX_RD_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Word stored at (row, addr): row and address are both visible in it.
    function automatic logic [DW-1:0] pat(input int r, input int a);
        return {8'hC3, 4'h0, 4'(r), 32'h0, 5'h0, 11'(a)};
    endfunction

    // Behavioural BRAM bank.
    logic [DW-1:0] bram_q [NR];
    always @(posedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (rd_en_row[r]) begin
                bram_q[r] <= pat(r, int'(rd_addr_row[r*RAW +: RAW]));
            end
        end
    end
    for (genvar r = 0; r < NR; r++) begin : g_bram_out
        assign rd_data_row[r*DW +: DW] = bram_q[r];
    end

    // Counters and scoreboard state.
    int    n_vec = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    beats = 0;
    int    pd_seen = 0;
    int    done_seen = 0;
    int    en_cycles = 0;
    int    stall_obs = 0;
    int    first_acc = -1;
    int    last_acc = -1;
    logic  chk_done_timing = 1'b0;
    beat_t exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            if (busy && idx_valid && !idx_ready) stall_obs++;
            if (rd_en_row != '0) begin
                en_cycles++;
                check("rd_en_onehot", 64'($countones(rd_en_row)), 64'd1);
            end
            if (idx_valid && !idx_ready) begin
                check("rd_en_on_stall", 64'(rd_en_row), 64'd0);
            end
            if (idx_valid && idx_ready) begin
                beats++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_row", 64'(idx_row), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_row",  64'(idx_row),  64'(e.row));
                    check("beat_data", idx_data,      e.data);
                    check("beat_last", 64'(idx_last), 64'(e.last));
                end
            end
            if (pass_done) pd_seen++;
            if (done) begin
                done_seen++;
                check("done_with_pass_done", 64'(pass_done), 64'd1);
                if (chk_done_timing) check("done_latency", 64'(cyc), 64'(last_acc + 1));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input int len, input int passes);
        beat_t b;
        for (int p = 0; p < passes; p++)
            for (int r = 0; r < NR; r++)
                for (int a = 0; a < len; a++) begin
                    b.row  = 4'(r);
                    b.data = pat(r, a);
                    b.last = (r == NR - 1) && (a == len - 1);
                    exp_q.push_back(b);
                end
    endtask

    // Start a tile; wr_finished either in the start cycle or 3 cycles later.
    task automatic run_tile(input int addr_end, input int pnum, input bit same_cycle);
        Addr_end    = (RAW+5)'(addr_end);
        pass_num    = PW'(pnum);
        start       = 1'b1;
        wr_finished = same_cycle;
        step(1);
        start       = 1'b0;
        wr_finished = 1'b0;
        if (!same_cycle) begin
            step(2);
            wr_finished = 1'b1;
            step(1);
            wr_finished = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int k = 0;
        int d0 = done_seen;
        while (done_seen == d0 && k < budget) begin
            if (toggle) idx_ready = ~idx_ready;
            step(1);
            k++;
        end
        check("done_timeout", 64'(done_seen != d0), 64'd1);
        idx_ready = 1'b1;
        step(2);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_idx_valid"}, 64'(idx_valid), 64'd0);
        check({tag, "_idx_data"},  idx_data,       64'd0);
        check({tag, "_idx_last"},  64'(idx_last),  64'd0);
        check({tag, "_rd_en"},     64'(rd_en_row), 64'd0);
        check({tag, "_rd_addr"},   64'(rd_addr_row != '0), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_pass_done"}, 64'(pass_done), 64'd0);
    endtask

    task automatic check_tile(input string tag, input int b0, input int pd0, input int d0,
                              input int e0, input int s0, input int xb, input int xpd);
        check({tag, "_beats"},     64'(beats - b0),     64'(xb));
        check({tag, "_en_cycles"}, 64'(en_cycles - e0), 64'(xb));
        check({tag, "_pass_done"}, 64'(pd_seen - pd0),  64'(xpd));
        check({tag, "_done_cnt"},  64'(done_seen - d0), 64'd1);
        check({tag, "_leftover"},  64'(exp_q.size()),   64'd0);
        check({tag, "_busy_end"},  64'(busy),           64'd0);
`ifdef IDX_RD_PERF_EN
        check({tag, "_stall_cnt"}, 64'(stall_cnt),      64'(stall_obs - s0));
`else
        if (s0 < 0) check({tag, "_stall_base"}, 64'(s0), 64'd0);
`endif
    endtask

    initial begin
        int b0, pd0, d0, e0, s0, k;

        // Reset state.
        step(3);
        check_quiet("reset");
        rst = 1'b1;
        step(1);

        // Test 1: len=4, single pass, consumer always ready.
        b0 = beats; pd0 = pd_seen; d0 = done_seen; e0 = en_cycles; s0 = stall_obs;
        first_acc = -1;
        chk_done_timing = 1'b1;
        push_tile(4, 1);
        run_tile(64, 0, 1'b0);
        wait_done(400, 1'b0);
        check_tile("t1", b0, pd0, d0, e0, s0, 64, 1);
        check("t1_no_gaps", 64'(last_acc - first_acc), 64'd63);

        // Test 2: same tile with idx_ready toggling every cycle.
        b0 = beats; pd0 = pd_seen; d0 = done_seen; e0 = en_cycles; s0 = stall_obs;
        push_tile(4, 1);
        run_tile(64, 0, 1'b0);
        wait_done(600, 1'b1);
        check_tile("t2", b0, pd0, d0, e0, s0, 64, 1);
        check("t2_stall_range", 64'((stall_obs - s0) >= 63 && (stall_obs - s0) <= 64), 64'd1);

        // Test 3: len=2, three passes.
        b0 = beats; pd0 = pd_seen; d0 = done_seen; e0 = en_cycles; s0 = stall_obs;
        push_tile(2, 3);
        run_tile(32, 2, 1'b0);
        wait_done(600, 1'b0);
        check_tile("t3", b0, pd0, d0, e0, s0, 96, 3);

        // Test 4: empty tile, start and wr_finished together.
        b0 = beats; pd0 = pd_seen; d0 = done_seen; e0 = en_cycles; s0 = stall_obs;
        chk_done_timing = 1'b0;
        run_tile(0, 0, 1'b1);
        wait_done(50, 1'b0);
        check_tile("t4", b0, pd0, d0, e0, s0, 0, 1);

        // Test 5: reset while a row-7 beat is presented, then a clean restart.
        push_tile(4, 1);
        run_tile(64, 0, 1'b0);
        k = 0;
        while (!(idx_valid && idx_row == 4'd7) && k < 300) begin
            step(1);
            k++;
        end
        check("t5_reached_row7", 64'(idx_valid && idx_row == 4'd7), 64'd1);
        rst = 1'b0;
        step(1);
        check_quiet("t5_after_rst");
        exp_q.delete();
        rst = 1'b1;
        step(1);
        b0 = beats; pd0 = pd_seen; d0 = done_seen; e0 = en_cycles; s0 = stall_obs;
        first_acc = -1;
        chk_done_timing = 1'b1;
        push_tile(4, 1);
        run_tile(64, 0, 1'b0);
        wait_done(400, 1'b0);
        check_tile("t5", b0, pd0, d0, e0, s0, 64, 1);
        check("t5_no_gaps", 64'(last_acc - first_acc), 64'd63);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: actual=%0d required=0", 1);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/index_buff_rd_sched.md
Name: index_buff_rd_sched

Overview:
- Read-side scheduler for the 16-row index BRAM bank that the index write controller fills.
- Waits until a tiling block has been fully written, then sequences reads row by row (row 0..15, address 0..len-1 in each row). Pass repeat lets one tile's index serve several output-channel groups.
- Presents one 64-bit index word per beat to the sparse PE front end over a valid/ready handshake.
- Outputs registered row/address tags and a last-flag.

Parameters:
- Ram_Row, 16, number of index BRAM rows (fixed at 16; row tag is 4 bits).
- Read_Addr_Width, 11, per-row BRAM address width.
- Data_Width, 64, index word width.
- Pass_Width, 4, width of the pass-count input.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-low (rst=0 resets).
- start  in  1  pulse: arm scheduler for a new tile.
- wr_finished  in  1  pulse from the write controller: tile fully written.
- Addr_end  in  Read_Addr_Width+5  total tile words; row length len = Addr_end>>4.
- pass_num  in  Pass_Width  number of full read passes minus 1; 0 means one pass.
- rd_data_row  in  Data_Width*Ram_Row  BRAM read data, row r at bits [r*Data_Width +: Data_Width].
- rd_addr_row  out  Read_Addr_Width*Ram_Row  per-row read address; active row only, others 0.
- rd_en_row  out  Ram_Row  one-hot read enable.
- idx_data  out  Data_Width  selected row's read data.
- idx_valid  out  1  idx_data valid.
- idx_ready  in  1  consumer accepts.
- idx_row  out  4  row tag of the current beat.
- idx_last  out  1  last beat of the current pass.
- pass_done  out  1  1-cycle pulse after the last beat of each pass is accepted.
- done  out  1  1-cycle pulse after the last beat of the last pass is accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: all outputs 0, state IDLE, counters 0.
- Latches at start: len and pass_num are captured when start is seen in IDLE and held for the whole tile.
- IDLE:
  - start -> WAIT_WR.
  - If wr_finished is high in the same cycle as start, go directly to READ.
- WAIT_WR: wr_finished -> READ.
- READ: issue condition is issue = (!idx_valid || idx_ready). On issue:
  - rd_en_row one-hot at the current row.
  - rd_addr_row carries the current column counter in that row's slice.
  - Column counter increments; at len-1 it wraps to 0 and the row counter increments.
  - After issuing row 15, address len-1 -> DRAIN.
- BRAM contract: 1-cycle read latency. The BRAM output must hold while its en is low.
- Output tags: idx_valid, idx_row and idx_last are registered one cycle after issue. idx_data is a combinational mux of rd_data_row selected by the registered idx_row.
  - On a cycle with idx_valid && idx_ready and no new issue, idx_valid clears.
  - Issue and accept in the same cycle keep idx_valid high (back-to-back throughput: 1 word/cycle).
- DRAIN: wait until the last beat (idx_last) is accepted, then pulse pass_done.
  - If pass_cnt < pass_num: increment pass_cnt, reset row/column, go to READ. The next first issue occurs in that same acceptance cycle +1.
  - Else: pulse done and go to IDLE.
- len = 0: no read is issued; pass_done and done pulse one cycle after entering READ; return to IDLE.
- start while not IDLE is ignored. wr_finished outside WAIT_WR/IDLE is ignored.
- Reset mid-operation: state returns to IDLE and all enables drop in the same clock edge. An in-flight beat is discarded.
- Addresses never exceed len-1. Row counter wraps only through DRAIN.

Optional Feature:
- Macro: IDX_RD_PERF_EN.
- Defined:
  - Adds output stall_cnt [15:0]: counts READ/DRAIN cycles with idx_valid && !idx_ready, saturating at 16'hFFFF.
  - Cleared on start acceptance and by reset.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package idx_buf_pkg:
  - State encodings IDLE/WAIT_WR/READ/DRAIN.
  - Ram_Row=16 and ROW_TAG_W=4 constants.
  - Function for row-length extraction (Addr_end>>4).
- One natural sub-module: idx_row_mux (16:1 Data_Width mux selected by idx_row).
- Everything else stays in the top level.

Test Plan:
- Addr_end=64 (len=4), pass_num=0, idx_ready=1, start then wr_finished 3 cycles later:
  - 64 beats in rows 0..15, addresses 0..3 each, no gaps.
  - idx_last on beat 64; done pulses the cycle after it.
- Same tile, idx_ready toggling 1/0 every cycle:
  - No beat lost or duplicated; idx_data/idx_row stable while stalled.
  - rd_en_row low on stalled cycles.
  - With IDX_RD_PERF_EN defined, stall_cnt ends at the number of stalled cycles.
- Addr_end=32, pass_num=2: three identical 32-beat sequences.
  - pass_done pulses 3 times, done once, total 96 beats.
- start and wr_finished in the same cycle with Addr_end=0:
  - No rd_en_row activity; pass_done and done pulse; busy returns to 0.
- rst driven low mid-row 7 with idx_valid=1:
  - Next cycle all outputs 0, state IDLE.
  - A fresh start/wr_finished restarts cleanly from row 0, address 0.
